// File: rtl/product_accumulator.sv
// Burst multiply-accumulate back end: sums a programmed-length stream of unsigned
// products into a wrapping accumulator with a sticky carry-out flag.
module product_accumulator #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);

    // One extra bit so a zero length field can encode the full 2**LEN_W burst
    localparam int unsigned CNT_W = LEN_W + 1;
    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_nxt;
    logic               ovf;
    logic               ovf_nxt;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;
    logic [SUM_W-1:0]   sum_ext;
    logic               beat;
    logic               finish;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        ovf_nxt   = ovf;
        count_nxt = count;
        beat      = 1'b0;
        finish    = 1'b0;
        sum_ext   = {1'b0, acc} + SUM_W'(in_data);

        case (state)
            IDLE: begin
                if (start) begin
                    count_nxt = (len == '0) ? (CNT_W'(1) << LEN_W) : CNT_W'(len);
                    acc_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                beat = in_valid && in_ready;
                if (beat) begin
                    acc_nxt   = sum_ext[ACC_W-1:0];
                    ovf_nxt   = ovf | sum_ext[ACC_W];
                    count_nxt = count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        finish    = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            ovf       <= 1'b0;
            count     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            acc       <= acc_nxt;
            ovf       <= ovf_nxt;
            count     <= count_nxt;
            in_ready  <= (state_nxt == ACCUM);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
            // Result registers hold the last burst until the next one completes
            if (finish) begin
                out_sum <= acc_nxt;
                out_ovf <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a default instance and an 8-bit
// accumulator instance that can overflow.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start, in_valid, out_ready;
    logic [3:0]  len;
    logic [7:0]  in_data;
    logic        in_ready, out_valid, out_ovf, busy;
    logic [15:0] out_sum;

    logic        start_8, in_valid_8, out_ready_8;
    logic [3:0]  len_8;
    logic [7:0]  in_data_8;
    logic        in_ready_8, out_valid_8, out_ovf_8, busy_8;
    logic [7:0]  out_sum_8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    product_accumulator #(.DATA_W(8), .ACC_W(16), .LEN_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_ovf(out_ovf), .busy(busy)
    );

    product_accumulator #(.DATA_W(8), .ACC_W(8), .LEN_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_8), .len(len_8),
        .in_valid(in_valid_8), .in_data(in_data_8), .in_ready(in_ready_8),
        .out_valid(out_valid_8), .out_ready(out_ready_8), .out_sum(out_sum_8),
        .out_ovf(out_ovf_8), .busy(busy_8)
    );

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 0; len = 0; in_valid = 0; in_data = 0; out_ready = 0;
        start_8 = 0; len_8 = 0; in_valid_8 = 0; in_data_8 = 0; out_ready_8 = 0;
        step(); step();
        n_vec++;
        if ({in_ready, out_valid, out_sum, out_ovf, busy} !== 20'd0) begin
            n_err++;
            $display("FAIL reset: got rdy=%b vld=%b sum=%0d ovf=%b busy=%b, want all 0",
                     in_ready, out_valid, out_sum, out_ovf, busy);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int lat = 0;
        int rdy_cnt = 0;
        int i = 0;
        start = 1; len = 4'd3;
        for (int c = 0; c < 20 && !out_valid; c++) begin
            step();
            start = 0;
            lat++;
            if (in_ready) begin
                rdy_cnt++;
                in_valid = 1;
                in_data  = (i == 0) ? 8'd10 : (i == 1) ? 8'd20 : 8'd30;
                i++;
            end else begin
                in_valid = 0;
            end
        end
        in_valid = 0;
        n_vec++;
        if (rdy_cnt != 3 || lat != 4) begin
            n_err++;
            $display("FAIL basic_timing: in_ready cycles=%0d latency=%0d, want 3 and 4", rdy_cnt, lat);
        end
        n_vec++;
        if (out_valid !== 1'b1 || out_sum !== 16'd60 || out_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL basic_result: vld=%b sum=%0d ovf=%b, want 1 60 0", out_valid, out_sum, out_ovf);
        end
        out_ready = 1;
        step();
        out_ready = 0;
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL basic_idle: vld=%b busy=%b rdy=%b, want 0 0 0", out_valid, busy, in_ready);
        end
    endtask

    task automatic test_full_len_bubbles();
        int acc_beats = 0;
        int c = 0;
        start = 1; len = 4'd0;
        step();
        start = 0;
        for (c = 0; c < 80 && !out_valid; c++) begin
            in_valid = c[0];
            in_data  = 8'hFF;
            if (in_valid && in_ready) acc_beats++;
            step();
        end
        in_valid = 0;
        n_vec++;
        if (acc_beats != 16 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL full_len_count: beats=%0d vld=%b, want 16 1", acc_beats, out_valid);
        end
        n_vec++;
        if (out_sum !== 16'h0FF0 || out_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL full_len_sum: sum=%h ovf=%b, want 0ff0 0", out_sum, out_ovf);
        end
        out_ready = 1;
        step();
        out_ready = 0;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL full_len_idle: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_backpressure();
        int held = 0;
        start = 1; len = 4'd2;
        step();
        len = 4'd1;
        in_valid = 1; in_data = 8'd5;   // start stays high: ignored in ACCUM
        step();
        in_data = 8'd7;
        step();
        in_valid = 0;
        // DONE: hold out_ready low for 4 cycles while pulsing start
        for (int k = 0; k < 5; k++) begin
            out_ready = (k == 4);
            start     = 1;
            if (out_valid === 1'b1 && out_sum === 16'd12 && out_ovf === 1'b0) held++;
            if (k < 4) step();
        end
        n_vec++;
        if (held != 5) begin
            n_err++;
            $display("FAIL backpressure_hold: stable cycles=%0d sum=%0d, want 5 12", held, out_sum);
        end
        step();
        start = 0; out_ready = 0;
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_idle: vld=%b busy=%b, want 0 0 (start with out_ready ignored)",
                     out_valid, busy);
        end
        step();
        n_vec++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_stay_idle: busy=%b rdy=%b, want 0 0", busy, in_ready);
        end
    endtask

    task automatic test_overflow();
        start_8 = 1; len_8 = 4'd2;
        step();
        start_8 = 0;
        in_valid_8 = 1; in_data_8 = 8'd200;
        step();
        in_data_8 = 8'd100;
        step();
        in_valid_8 = 0;
        n_vec++;
        if (out_valid_8 !== 1'b1 || out_sum_8 !== 8'd44 || out_ovf_8 !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set: vld=%b sum=%0d ovf=%b, want 1 44 1", out_valid_8, out_sum_8, out_ovf_8);
        end
        out_ready_8 = 1;
        step();
        out_ready_8 = 0;
        start_8 = 1; len_8 = 4'd1;
        step();
        start_8 = 0;
        in_valid_8 = 1; in_data_8 = 8'd3;
        step();
        in_valid_8 = 0;
        n_vec++;
        if (out_valid_8 !== 1'b1 || out_sum_8 !== 8'd3 || out_ovf_8 !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: vld=%b sum=%0d ovf=%b, want 1 3 0", out_valid_8, out_sum_8, out_ovf_8);
        end
        out_ready_8 = 1;
        step();
        out_ready_8 = 0;
    endtask

    task automatic test_mid_reset();
        start = 1; len = 4'd4;
        step();
        start = 0;
        in_valid = 1; in_data = 8'd50;
        step();
        step();
        in_valid = 0;
        rst_n = 0;
        #1;
        n_vec++;
        if ({in_ready, out_valid, out_sum, out_ovf, busy} !== 20'd0) begin
            n_err++;
            $display("FAIL mid_reset: rdy=%b vld=%b sum=%0d ovf=%b busy=%b, want all 0",
                     in_ready, out_valid, out_sum, out_ovf, busy);
        end
        step();
        rst_n = 1;
        step();
        start = 1; len = 4'd1;
        step();
        start = 0;
        in_valid = 1; in_data = 8'd9;
        step();
        in_valid = 0;
        n_vec++;
        if (out_valid !== 1'b1 || out_sum !== 16'd9) begin
            n_err++;
            $display("FAIL mid_reset_restart: vld=%b sum=%0d, want 1 9", out_valid, out_sum);
        end
        out_ready = 1;
        step();
        out_ready = 0;
    endtask

    task automatic test_ignore_data();
        in_valid = 1; in_data = 8'd99;
        step(); step();
        n_vec++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ignore: rdy=%b busy=%b, want 0 0", in_ready, busy);
        end
        start = 1; len = 4'd1;
        step();
        start = 0;
        in_data = 8'd4;
        step();
        in_data = 8'd99;           // in_valid stays high through DONE
        step(); step();
        n_vec++;
        if (out_valid !== 1'b1 || out_sum !== 16'd4 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL done_ignore: vld=%b sum=%0d rdy=%b, want 1 4 0", out_valid, out_sum, in_ready);
        end
        in_valid = 0;
        out_ready = 1;
        step();
        out_ready = 0;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_idle: busy=%b, want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_len_bubbles();
        test_backpressure();
        test_overflow();
        test_mid_reset();
        test_ignore_data();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
